serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
Serial frame transmitter for the sync-pattern detector path. It accepts a parallel payload word through a valid/ready handshake. It emits a fixed preamble and then the payload, one bit per clock, MSB first, followed by an idle gap. The serial output feeds the team's bit-serial pattern detectors, which lock on the preamble (default 101).

Parameters:
PRE_W, 3, preamble length in bits (>=1)
PREAMBLE, 3'b101, preamble pattern; bit PRE_W-1 is sent first
DATA_W, 8, payload width in bits (>=1)
GAP, 2, idle zero-bit cycles after each payload (>=0)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  DATA_W  payload word
din_valid  input  1  payload offered
din_ready  output  1  block can accept payload
sout  output  1  serial bit
sout_valid  output  1  sout carries a preamble or payload bit
busy  output  1  frame in progress (preamble, payload or gap)
frame_done  output  1  one-cycle pulse coincident with last payload bit

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - While rst is high at an edge, the FSM goes to IDLE, the shift register and counter clear, and din_valid is ignored.
  - Values after a reset edge: sout=0, sout_valid=0, busy=0, frame_done=0, din_ready=1.
- FSM states: IDLE, PRE, DATA, GAP. sout, sout_valid, busy and frame_done are registered. din_ready is decoded from state (1 only in IDLE).
- IDLE:
  - Handshake occurs at the edge where din_valid && din_ready (edge E0).
  - At E0, din is captured into a DATA_W shift register, the counter loads PRE_W-1, and the state moves to PRE.
  - din and din_valid are ignored at every edge outside IDLE. Changes to din after E0 do not affect the frame.
- PRE:
  - From E0 for PRE_W cycles: sout = PREAMBLE[PRE_W-1] down to PREAMBLE[0], sout_valid=1, busy=1.
  - After the last preamble bit, the counter loads DATA_W-1 and the state moves to DATA.
- DATA:
  - For DATA_W cycles: sout = payload MSB first (shift left), sout_valid=1, busy=1.
  - frame_done=1 only during the cycle showing payload bit 0.
  - Exit goes to GAP if GAP>0, else IDLE.
- GAP:
  - For GAP cycles: sout=0, sout_valid=0, busy=1, din_ready=0. Then the state moves to IDLE.
- Outside PRE/DATA: sout=0 and sout_valid=0, always.
- Timing:
  - First serial bit is visible in the cycle after E0. Frame length is PRE_W+DATA_W+GAP cycles.
  - din_ready returns 1 in the cycle after the last gap bit, or after the last payload bit when GAP=0.
  - Minimum accept-to-accept spacing is PRE_W+DATA_W+GAP+1 edges, because one IDLE cycle is mandatory.
- Counter width: $clog2(max(PRE_W,DATA_W,GAP)+1). It counts down to 0 and never wraps.
- Reset mid-frame: the frame aborts at the reset edge. sout and sout_valid drop to 0 in the next cycle. No frame_done is produced, and the partial payload is discarded.
- din_valid high during reset: no capture occurs. The first legal accept is the first edge with rst=0.

Test Plan:
1. Defaults, din=8'hA5 held one cycle with din_valid -> sout over 11 cycles = 1,0,1,1,0,1,0,0,1,0,1 with sout_valid=1 throughout. frame_done is high in cycle 11 only. Two cycles follow with sout_valid=0, busy=1. din_ready=1 and busy=0 in cycle 14.
2. din_valid held high with din=8'h3C then 8'hFF -> frames start at edges spaced exactly 14 cycles apart. Payload bits are 00111100 then 11111111, each preceded by 101.
3. Accept 8'h81, then change din to 8'h00 and toggle din_valid during the frame -> payload still 10000001, and no extra frame starts before din_ready=1.
4. Assert rst for 1 cycle during the 4th payload bit of 8'hF0 -> next cycle sout=0, sout_valid=0, busy=0, din_ready=1. No frame_done. The next accepted word 8'h0F is sent in full and correctly.
5. Parameter variant GAP=0, DATA_W=4, PREAMBLE=3'b110, din=4'h9 -> bits 1,1,0,1,0,0,1 over 7 cycles. din_ready=1 in the next cycle, and the accept spacing is 8.
6. din_valid=1 with din=8'hFF while rst=1 for 3 cycles -> no sout_valid during reset. Release reset -> the accept occurs on the first non-reset edge and the frame begins the cycle after.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: a valid/ready handshake captures one payload word,
// then the block emits PREAMBLE, the payload MSB first, and GAP idle bits.
// The serial outputs are registered. din_ready is decoded from the FSM state.
module serial_pattern_tx #(
  parameter int              PRE_W    = 3,
  parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
  parameter int              DATA_W   = 8,
  parameter int              GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              frame_done
);

  // Preamble and payload share one shift register. Its MSB is the bit on sout.
  localparam int FW   = PRE_W + DATA_W;
  localparam int MAXC = (PRE_W > DATA_W) ? ((PRE_W > GAP) ? PRE_W : GAP)
                                         : ((DATA_W > GAP) ? DATA_W : GAP);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [FW-1:0] r_sh, w_sh_nxt;
  logic          r_sout, w_sout_nxt;
  logic          r_sout_valid, w_sout_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  // State, counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sh         <= w_sh_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next state plus the next values of the registered outputs. r_cnt holds the
  // number of cycles left in the current state after the one being shown.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sh_nxt         = r_sh;
    w_sout_nxt       = 1'b0;
    w_sout_valid_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_state_nxt      = S_PRE;
          w_cnt_nxt        = CW'(PRE_W - 1);
          w_sh_nxt         = {PREAMBLE, din};
          w_sout_nxt       = PREAMBLE[PRE_W-1];
          w_sout_valid_nxt = 1'b1;
          w_busy_nxt       = 1'b1;
        end
      end
      S_PRE: begin
        // The following bit is either the next preamble bit or the payload MSB.
        w_sh_nxt         = r_sh << 1;
        w_sout_nxt       = r_sh[FW-2];
        w_sout_valid_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CW'(DATA_W - 1);
          w_done_nxt  = (DATA_W == 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = CW'(GAP - 1);
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt        = r_cnt - CW'(1);
          w_sh_nxt         = r_sh << 1;
          w_sout_nxt       = r_sh[FW-2];
          w_sout_valid_nxt = 1'b1;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = (r_cnt == CW'(1));
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt  = r_cnt - CW'(1);
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign din_ready  = (r_state == S_IDLE);
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx. It uses a table of payload words with their
// expected frames, a cycle scoreboard for the default instance, and a second
// instance with GAP=0, DATA_W=4 and PREAMBLE=110.
module tb_serial_pattern_tx;

  localparam int FL = 13;  // 3 preamble + 8 payload + 2 gap cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, sout, sout_valid, busy, frame_done;

  logic [3:0] din2 = '0;
  logic       din_valid2 = 1'b0;
  logic       din_ready2, sout2, sout_valid2, busy2, frame_done2;

  serial_pattern_tx u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .frame_done(frame_done)
  );

  serial_pattern_tx #(.PRE_W(3), .PREAMBLE(3'b110), .DATA_W(4), .GAP(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
    .sout(sout2), .sout_valid(sout_valid2), .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int m_left = 0;
  bit mon_en = 1'b0;
  logic [10:0] exp_frame = '0;

  typedef struct packed { logic b; logic last; } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0]  din;
    bit          hold;      // keep din_valid high into the next record
    logic [10:0] exp_bits;  // preamble then payload, first bit at [10]
  } vec_t;
  vec_t tbl[4];
  int acc[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (din_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk_int("wait_ready_timeout", n, 0);
  endtask

  // Check the outputs of the current cycle, then predict the next edge.
  always @(negedge clk) begin
    sb_t e;
    logic ev;
    if (mon_en) begin
      ev = (sb_q.size() > 0);
      e = '0;
      if (ev) e = sb_q.pop_front();
      chk("sout_valid", sout_valid, ev);
      chk("sout", sout, e.b);
      chk("frame_done", frame_done, e.last);
      chk("busy", busy, m_left > 0);
      chk("din_ready", din_ready, m_left == 0);
      if (frame_done === 1'b1) fd_cnt++;
    end
    if (rst) begin
      sb_q.delete();
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (din_valid) begin
      for (int i = 10; i >= 0; i--) sb_q.push_back('{b: exp_frame[i], last: (i == 0)});
      m_left = FL;
    end
  end

  initial begin
    logic [6:0] exp5;
    tbl[0] = '{din: 8'hA5, hold: 1'b0, exp_bits: 11'b101_10100101};
    tbl[1] = '{din: 8'h3C, hold: 1'b1, exp_bits: 11'b101_00111100};
    tbl[2] = '{din: 8'hFF, hold: 1'b1, exp_bits: 11'b101_11111111};
    tbl[3] = '{din: 8'h55, hold: 1'b0, exp_bits: 11'b101_01010101};
    exp5 = 7'b110_1001;

    // Reset, then the variant instance (GAP=0, DATA_W=4) with din_valid2 held high
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    din2 = 4'h9;
    din_valid2 = 1'b1;
    chk("v2_ready_reset", din_ready2, 1'b1);
    chk("v2_valid_reset", sout_valid2, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("v2_sout", sout2, exp5[6-i]);
      chk("v2_sout_valid", sout_valid2, 1'b1);
      chk("v2_frame_done", frame_done2, i == 6);
      chk("v2_ready_busy", din_ready2, 1'b0);
      tick();
    end
    chk("v2_ready_after", din_ready2, 1'b1);
    chk("v2_busy_after", busy2, 1'b0);
    chk("v2_valid_after", sout_valid2, 1'b0);
    tick();
    chk("v2_spacing8_valid", sout_valid2, 1'b1);
    chk("v2_spacing8_bit", sout2, 1'b1);
    din_valid2 = 1'b0;

    // Table of frames; a held din_valid gives back-to-back accepts
    for (int i = 0; i < 4; i++) begin
      din = tbl[i].din;
      exp_frame = tbl[i].exp_bits;
      din_valid = 1'b1;
      wait_ready();
      acc[i] = cyc;
      tick();
      if (!tbl[i].hold) din_valid = 1'b0;
      if (i > 0 && tbl[i-1].hold) chk_int("accept_spacing", acc[i] - acc[i-1], 14);
    end
    din_valid = 1'b0;
    wait_ready();

    // Inputs that change during a frame are ignored
    din = 8'h81;
    exp_frame = 11'b101_10000001;
    din_valid = 1'b1;
    tick();
    din = 8'h00;
    exp_frame = 11'b101_00000000;
    for (int i = 0; i < 10; i++) begin
      din_valid = ~din_valid;
      tick();
    end
    din_valid = 1'b0;
    wait_ready();
    tick();

    // Reset during the 4th payload bit of F0
    din = 8'hF0;
    exp_frame = 11'b101_11110000;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_bit4_valid", sout_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sout_valid", sout_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", din_ready, 1'b1);
    din = 8'h0F;
    exp_frame = 11'b101_00001111;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    wait_ready();

    // din_valid held high through reset
    din = 8'hFF;
    exp_frame = 11'b101_11111111;
    din_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_valid", sout_valid, 1'b0);
    end
    rst = 1'b0;
    chk("rst_release_ready", din_ready, 1'b1);
    tick();
    din_valid = 1'b0;
    chk("rst_first_accept", sout_valid, 1'b1);
    wait_ready();
    tick(); tick();

    chk_int("frame_done_count", fd_cnt, 7);
    chk_int("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
